// File: rtl/timer_run_ctrl.sv
// -----------------------------------------------------------------------------
// timer_run_ctrl
//
// Countdown controller for a mm:ss BCD egg timer. It takes the value committed
// by the time-set service, runs it down at one tick per TICK_DIV clocks, and
// sequences load / start / pause / resume / clear / alarm. While the set
// service is active it owns the buttons and the display; the countdown itself
// keeps running underneath.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   load        1-cycle pulse: capture set_num as the new count
//   set_num     BCD m1 m0 s1 s0 from the set service
//   set_active  set service owns buttons and display
//   push_c      1-cycle pulse: start / pause / resume / alarm acknowledge
//   push_clr    1-cycle pulse: abort to IDLE
//   disp_num    BCD value for the 7-segment driver (registered)
//   disp_blank  per-digit blank, 1 = dark (registered)
//   alarm       high throughout ALARM
//   running     high in RUN
//   done        1-cycle pulse when RUN enters ALARM
//   state       IDLE=0, READY=1, RUN=2, PAUSE=3, ALARM=4
// -----------------------------------------------------------------------------
module timer_run_ctrl #(
   parameter int TICK_DIV    = 100_000_000,
   parameter int ALARM_TICKS = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] set_num,
   input  logic        set_active,
   input  logic        push_c,
   input  logic        push_clr,
   output logic [15:0] disp_num,
   output logic [3:0]  disp_blank,
   output logic        alarm,
   output logic        running,
   output logic        done,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READY = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_ALARM = 3'd4
   } state_e;

   localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HALF = (TICK_DIV / 2 > 0) ? TICK_DIV / 2 : 1;
   localparam int HW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int AW   = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HALF_MAX  = HW'(HALF - 1);
   localparam logic [AW-1:0] ALARM_MAX = AW'(ALARM_TICKS - 1);

   // One-second BCD decrement. s1 only borrows to 5, so loaded tens-of-seconds
   // above 5 simply count down until they first borrow.
   function automatic logic [15:0] bcd_dec(input logic [15:0] v);
      logic [3:0] s0, s1, m0, m1;
      logic       b;
      b  = (v[3:0] == 4'd0);
      s0 = b ? 4'd9 : v[3:0] - 4'd1;
      s1 = v[7:4];
      if (b) begin
         s1 = (v[7:4] == 4'd0) ? 4'd5 : v[7:4] - 4'd1;
         b  = (v[7:4] == 4'd0);
      end
      m0 = v[11:8];
      if (b) begin
         m0 = (v[11:8] == 4'd0) ? 4'd9 : v[11:8] - 4'd1;
         b  = (v[11:8] == 4'd0);
      end
      m1 = b ? v[15:12] - 4'd1 : v[15:12];
      return {m1, m0, s1, s0};
   endfunction

   state_e          state_q, state_d;
   logic [15:0]     count_q, count_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [AW-1:0]   alarm_cnt_q, alarm_cnt_d;
   logic [HW-1:0]   half_cnt_q, half_cnt_d;
   logic            pause_blink_q, pause_blink_d;
   logic            alarm_blank_q, alarm_blank_d;
   logic [15:0]     disp_num_q, disp_num_d;
   logic [3:0]      disp_blank_q, disp_blank_d;
   logic            alarm_q, alarm_d;
   logic            running_q, running_d;
   logic            done_q, done_d;

   logic            btn_c, btn_clr, tick;
   logic [15:0]     dec_val;

   // Buttons belong to the set service while it is active.
   assign btn_c   = push_c   & ~set_active;
   assign btn_clr = push_clr & ~set_active;

   assign tick = ((state_q == ST_RUN) || (state_q == ST_ALARM)) && (presc_q == PRESC_MAX);

   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path through the case statements can leave it unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      presc_d       = presc_q;
      alarm_cnt_d   = alarm_cnt_q;
      alarm_blank_d = alarm_blank_q;
      dec_val       = (count_q != 16'h0000) ? bcd_dec(count_q) : count_q;

      if ((state_q == ST_RUN) || (state_q == ST_ALARM)) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (load && (set_num != 16'h0000)) begin
               state_d = ST_READY;
               count_d = set_num;
            end
         end
         ST_READY: begin
            if (btn_clr) begin
               state_d = ST_IDLE;
               count_d = 16'h0000;
            end else if (btn_c) begin
               state_d = ST_RUN;
               presc_d = '0;
            end else if (load) begin
               count_d = set_num;
               state_d = (set_num == 16'h0000) ? ST_IDLE : ST_READY;
            end
         end
         ST_RUN: begin
            if (btn_clr) begin
               state_d = ST_IDLE;
               count_d = 16'h0000;
            end else begin
               // A coincident tick is applied first; reaching zero beats pause.
               if (tick) begin
                  count_d = dec_val;
               end
               if (tick && (dec_val == 16'h0000)) begin
                  state_d       = ST_ALARM;
                  presc_d       = '0;
                  alarm_blank_d = 1'b1;
               end else if (btn_c) begin
                  state_d = ST_PAUSE;
               end
            end
         end
         ST_PAUSE: begin
            if (btn_clr) begin
               state_d = ST_IDLE;
               count_d = 16'h0000;
            end else if (btn_c) begin
               state_d = ST_RUN;
            end else if (load) begin
               count_d = set_num;
               state_d = (set_num == 16'h0000) ? ST_IDLE : ST_READY;
            end
         end
         ST_ALARM: begin
            if (tick) begin
               alarm_cnt_d   = alarm_cnt_q + 1'b1;
               alarm_blank_d = ~alarm_blank_q;
            end
            if (btn_clr || btn_c) begin
               state_d = ST_IDLE;
            end else if (load) begin
               count_d = set_num;
               state_d = (set_num == 16'h0000) ? ST_IDLE : ST_READY;
            end else if (tick && (alarm_cnt_q == ALARM_MAX)) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = 16'h0000;
         end
      endcase

      if (state_d != ST_ALARM) begin
         alarm_cnt_d = '0;
      end

      // Free-running half-period counter for the PAUSE blink.
      half_cnt_d    = (half_cnt_q == HALF_MAX) ? '0 : half_cnt_q + 1'b1;
      pause_blink_d = (half_cnt_q == HALF_MAX) ? ~pause_blink_q : pause_blink_q;

      // Status outputs follow the next state so they move with the state register.
      alarm_d   = (state_d == ST_ALARM);
      running_d = (state_d == ST_RUN);
      done_d    = (state_q == ST_RUN) && (state_d == ST_ALARM);

      // Display mux, registered from the current state/count.
      disp_num_d   = 16'h0000;
      disp_blank_d = 4'b0000;
      if (set_active) begin
         disp_num_d = set_num;
      end else begin
         case (state_q)
            ST_READY, ST_RUN: disp_num_d = count_q;
            ST_PAUSE: begin
               disp_num_d   = count_q;
               disp_blank_d = {4{pause_blink_q}};
            end
            ST_ALARM: disp_blank_d = {4{alarm_blank_q}};
            default: ;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the values from before the edge regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         count_q       <= 16'h0000;
         presc_q       <= '0;
         alarm_cnt_q   <= '0;
         half_cnt_q    <= '0;
         pause_blink_q <= 1'b0;
         alarm_blank_q <= 1'b0;
         disp_num_q    <= 16'h0000;
         disp_blank_q  <= 4'b0000;
         alarm_q       <= 1'b0;
         running_q     <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         presc_q       <= presc_d;
         alarm_cnt_q   <= alarm_cnt_d;
         half_cnt_q    <= half_cnt_d;
         pause_blink_q <= pause_blink_d;
         alarm_blank_q <= alarm_blank_d;
         disp_num_q    <= disp_num_d;
         disp_blank_q  <= disp_blank_d;
         alarm_q       <= alarm_d;
         running_q     <= running_d;
         done_q        <= done_d;
      end
   end

   assign disp_num   = disp_num_q;
   assign disp_blank = disp_blank_q;
   assign alarm      = alarm_q;
   assign running    = running_q;
   assign done       = done_q;
   assign state      = state_q;

endmodule

// File: tb/tb_timer_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_run_ctrl
//
// Directed bench for timer_run_ctrl with TICK_DIV=4, ALARM_TICKS=10. Inputs
// are driven and outputs sampled 1 ns after each rising edge. Cycle numbers in
// the comments count edges after the start (push_c) edge S.
// -----------------------------------------------------------------------------
module tb_timer_run_ctrl;

   logic        clk;
   logic        reset;
   logic        load;
   logic [15:0] set_num;
   logic        set_active;
   logic        push_c;
   logic        push_clr;
   logic [15:0] disp_num;
   logic [3:0]  disp_blank;
   logic        alarm;
   logic        running;
   logic        done;
   logic [2:0]  state;

   int n_checks = 0;
   int n_fail   = 0;

   timer_run_ctrl #(
      .TICK_DIV   (4),
      .ALARM_TICKS(10)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .set_num   (set_num),
      .set_active(set_active),
      .push_c    (push_c),
      .push_clr  (push_clr),
      .disp_num  (disp_num),
      .disp_blank(disp_blank),
      .alarm     (alarm),
      .running   (running),
      .done      (done),
      .state     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_load(input logic [15:0] v);
      set_num = v;
      load    = 1'b1;
      cyc();
      load    = 1'b0;
   endtask

   task automatic pulse_c();
      push_c = 1'b1;
      cyc();
      push_c = 1'b0;
   endtask

   task automatic pulse_clr();
      push_clr = 1'b1;
      cyc();
      push_clr = 1'b0;
   endtask

   initial begin
      logic frozen, saw_dark, saw_lit;

      reset      = 1'b1;
      load       = 1'b0;
      set_num    = 16'h0000;
      set_active = 1'b0;
      push_c     = 1'b0;
      push_clr   = 1'b0;
      #23;
      check("rst_state", 16'(state), 16'd0);
      check("rst_disp", disp_num, 16'h0000);
      check("rst_flags", {12'd0, alarm, running, done, 1'b0}, 16'd0);
      reset = 1'b0;
      cyc();

      // ---- basic countdown 00:03 -> alarm -> auto return -----------------
      pulse_load(16'h0003);
      check("t2_ready", 16'(state), 16'd1);
      pulse_c();
      check("t2_run", 16'(state), 16'd2);
      check("t2_running", 16'(running), 16'd1);
      for (int c = 1; c <= 52; c++) begin
         cyc();
         if (c == 4)  check("t2_disp3", disp_num, 16'h0003);
         if (c == 5)  check("t2_disp2", disp_num, 16'h0002);
         if (c == 9)  check("t2_disp1", disp_num, 16'h0001);
         if (c == 11) check("t2_nodone_early", 16'(done), 16'd0);
         if (c == 12) begin
            check("t2_alarm_state", 16'(state), 16'd4);
            check("t2_done", 16'(done), 16'd1);
            check("t2_alarm", 16'(alarm), 16'd1);
         end
         if (c == 13) begin
            check("t2_done_1cyc", 16'(done), 16'd0);
            check("t2_alarm_disp", disp_num, 16'h0000);
            check("t2_alarm_blank_entry", 16'(disp_blank), 16'hF);
         end
         if (c == 17) check("t2_alarm_blink", 16'(disp_blank), 16'h0);
         if (c == 51) check("t2_still_alarm", 16'(state), 16'd4);
         if (c == 52) begin
            check("t2_auto_idle", 16'(state), 16'd0);
            check("t2_alarm_off", 16'(alarm), 16'd0);
         end
      end

      // ---- BCD borrows ---------------------------------------------------
      pulse_load(16'h0100);
      pulse_c();
      repeat (5) cyc();
      check("t3_0100_dec", disp_num, 16'h0059);
      pulse_clr();
      check("t3_clr_idle", 16'(state), 16'd0);
      cyc();
      check("t3_clr_disp", disp_num, 16'h0000);
      pulse_load(16'h1000);
      pulse_c();
      repeat (5) cyc();
      check("t3_1000_dec", disp_num, 16'h0959);
      pulse_clr();

      // ---- pause with prescaler at 2, blink, resume ----------------------
      pulse_load(16'h0010);
      pulse_c();
      cyc();
      cyc();
      pulse_c();
      check("t4_pause", 16'(state), 16'd3);
      check("t4_not_running", 16'(running), 16'd0);
      frozen   = 1'b1;
      saw_dark = 1'b0;
      saw_lit  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (disp_num != 16'h0010) frozen = 1'b0;
         if (disp_blank == 4'hF) saw_dark = 1'b1;
         if (disp_blank == 4'h0) saw_lit = 1'b1;
      end
      check("t4_frozen", 16'(frozen), 16'd1);
      check("t4_blink_dark", 16'(saw_dark), 16'd1);
      check("t4_blink_lit", 16'(saw_lit), 16'd1);
      check("t4_still_pause", 16'(state), 16'd3);
      pulse_c();
      check("t4_resume", 16'(state), 16'd2);
      cyc();
      check("t4_resume_p1", disp_num, 16'h0010);
      cyc();
      check("t4_resume_tick", disp_num, 16'h0009);
      pulse_clr();

      // ---- push_c coincident with final tick: alarm wins -----------------
      pulse_load(16'h0002);
      pulse_c();
      repeat (7) cyc();
      pulse_c();
      check("t5_alarm_wins", 16'(state), 16'd4);
      check("t5_done", 16'(done), 16'd1);
      pulse_c();
      check("t5_ack_idle", 16'(state), 16'd0);
      check("t5_ack_alarm_off", 16'(alarm), 16'd0);

      // ---- push_clr coincident with a tick -------------------------------
      pulse_load(16'h0005);
      pulse_c();
      repeat (3) cyc();
      pulse_clr();
      check("t5_clr_idle", 16'(state), 16'd0);
      check("t5_clr_running", 16'(running), 16'd0);
      cyc();
      check("t5_clr_disp", disp_num, 16'h0000);

      // ---- set service owns display and buttons --------------------------
      pulse_load(16'h0030);
      pulse_c();
      set_active = 1'b1;
      set_num    = 16'h4242;
      cyc();
      check("t6_set_disp", disp_num, 16'h4242);
      pulse_c();
      check("t6_c_ignored", 16'(state), 16'd2);
      check("t6_running", 16'(running), 16'd1);
      repeat (8) cyc();
      check("t6_set_disp_hold", disp_num, 16'h4242);
      set_active = 1'b0;
      set_num    = 16'h0000;
      cyc();
      check("t6_count_underneath", disp_num, 16'h0028);
      set_num = 16'h0111;
      load    = 1'b1;
      cyc();
      load    = 1'b0;
      check("t6_load_ignored_state", 16'(state), 16'd2);
      cyc();
      check("t6_load_ignored_count", disp_num, 16'h0027);
      pulse_clr();
      pulse_load(16'h0000);
      check("t6_zero_load_idle", 16'(state), 16'd0);
      pulse_load(16'h0007);
      check("t6_ready_again", 16'(state), 16'd1);
      pulse_load(16'h0000);
      check("t6_ready_zero_idle", 16'(state), 16'd0);

      // ---- asynchronous reset mid-RUN ------------------------------------
      pulse_load(16'h0005);
      pulse_c();
      cyc();
      cyc();
      check("t1_pre_running", 16'(running), 16'd1);
      #2;
      reset = 1'b1;
      #1;
      check("t1_async_state", 16'(state), 16'd0);
      check("t1_async_disp", disp_num, 16'h0000);
      check("t1_async_flags", {11'd0, disp_blank == 4'h0 ? 1'b0 : 1'b1, alarm, running, done, 1'b0}, 16'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      cyc();
      check("t1_post_state", 16'(state), 16'd0);
      check("t1_post_running", 16'(running), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_run_ctrl.md
Name: timer_run_ctrl

Overview:
- Countdown controller that consumes the mm:ss BCD value committed by the time-set service and runs it down at 1 Hz.
- Sequences load, start, pause, resume, clear and alarm.
- Arbitrates the shared centre/down push buttons and the 4-digit display between the set service and the running timer.
- Sits between the time-set service and the 7-segment driver in the top level.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per 1 s tick. Benches use 4.
- ALARM_TICKS, 10: ticks spent in ALARM before auto-return to IDLE.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- load  in  1  single-cycle pulse from the set service (its finish strobe); capture set_num
- set_num  in  16  BCD m1 m0 s1 s0, bits [15:12] [11:8] [7:4] [3:0], each digit 0-9
- set_active  in  1  set service owns buttons and display (spdt1 level)
- push_c  in  1  single-cycle debounced pulse: start / pause / resume / alarm acknowledge
- push_clr  in  1  single-cycle debounced pulse: abort to IDLE
- disp_num  out  16  BCD value for the 7-segment driver
- disp_blank  out  4  per-digit blank, 1 = dark
- alarm  out  1  high throughout ALARM
- running  out  1  high in RUN
- done  out  1  single-cycle pulse on the cycle RUN enters ALARM
- state  out  3  IDLE=0, READY=1, RUN=2, PAUSE=3, ALARM=4

Behaviour:
Reset, asynchronous:
- state=IDLE; count=0; prescaler=0; alarm_cnt=0.
- disp_num=0, disp_blank=0, alarm=0, running=0, done=0.

Button gating:
- push_c and push_clr are ignored on any cycle where set_active=1.

Tick generation:
- The prescaler counts 0..TICK_DIV-1 in RUN and ALARM only.
- tick=1 when prescaler==TICK_DIV-1; the prescaler wraps to 0 on that cycle.
- The prescaler holds its value in PAUSE.
- The prescaler clears to 0 on entry to RUN from READY and on entry to ALARM.

State transitions:
- IDLE: load with set_num!=0 -> READY, count<=set_num. load with set_num==0 -> stay IDLE.
- READY: push_c -> RUN. push_clr -> IDLE, count<=0. load -> reload count (set_num==0 -> IDLE).
- RUN: on tick, count decrements one second.
  - If the decremented value is 0000, go to ALARM on that same edge and pulse done for one cycle.
  - push_c -> PAUSE. If push_c and tick coincide, the decrement is applied, then PAUSE (or ALARM if it reached zero; ALARM wins).
  - push_clr -> IDLE, count<=0. push_clr has priority over tick and push_c.
  - load is ignored in RUN.
- PAUSE: push_c -> RUN; the prescaler resumes from its held value. push_clr -> IDLE, count<=0. load -> READY with reload (zero -> IDLE).
- ALARM: alarm_cnt increments per tick.
  - alarm_cnt==ALARM_TICKS-1 with tick -> IDLE.
  - push_c or push_clr -> IDLE immediately.
  - load -> READY with reload (zero -> IDLE).
  - alarm_cnt clears on exit.

BCD decrement rules:
- s0: 0 -> 9 with borrow, else s0-1.
- s1: on borrow, 0 -> 5 with borrow, else s1-1.
- m0: on borrow, 0 -> 9 with borrow, else m0-1.
- m1: on borrow, m1-1.
- 00:00 is never decremented.
- Loaded s1 values 6-9 count down as loaded (e.g. 00:99 -> 00:98), then borrow to 5.

Display mux (registered, 1-cycle latency from state/count):
- set_active=1: disp_num=set_num, disp_blank=0000, in any state; counting continues unaffected.
- Otherwise:
  - IDLE: disp_num=0000, disp_blank=0000.
  - READY, RUN, PAUSE: disp_num=count.
  - PAUSE: disp_blank toggles 0000/1111 every TICK_DIV/2 clk cycles, using a separate free-running half-period counter.
  - ALARM: disp_num=0000; disp_blank toggles 0000/1111 on every tick, starting blank on entry.

Other outputs:
- alarm, running, done and state are registered and change on the same edge as the state register.

Test Plan:
1. reset mid-RUN (count 00:05): assert reset asynchronously -> all outputs 0 the same instant; state=IDLE after release.
2. TICK_DIV=4, load set_num=16'h0003, push_c -> RUN.
   - disp_num 0003 -> 0002 -> 0001 -> 0000 at 4-cycle spacing.
   - done pulses once as state=4; alarm=1.
   - After 10 ticks: IDLE, alarm=0.
3. load 16'h0100, start, 1 tick -> disp_num=16'h0059. load 16'h1000, 1 tick -> 16'h0959.
4. RUN with prescaler at 2, push_c -> PAUSE: count frozen and disp_blank blinking for 20 cycles. push_c -> RUN: next tick arrives 1 cycle after resume.
5. push_c coincident with tick at count 0001 -> ALARM (not PAUSE), done=1. Separately, push_clr coincident with tick -> IDLE, count=0.
6. set_active=1 during RUN with set_num=16'h4242:
   - disp_num=4242.
   - push_c pulses ignored (running stays 1).
   - Internal count keeps decrementing; visible on set_active=0.
   - load 0000 in IDLE -> stays IDLE.
